// File: rtl/game_ctrl.sv
// Game-flow sequencer: button debounce, ATTRACT/PLAY/CRASH/OVER control,
// datapath reset/freeze, crash flash timing and high-score capture.
module game_ctrl #(
    parameter int DEBOUNCE_CYC     = 250000,
    parameter int CRASH_FRAMES     = 60,
    parameter int FLASH_FRAMES     = 8,
    parameter int OVER_HOLD_FRAMES = 30
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_move_btn,
    input  logic       i_frame_tick,
    input  logic       i_collision,
    input  logic [7:0] i_score,
    output logic       o_game_rst,
    output logic       o_scroll_en,
    output logic       o_move_pulse,
    output logic       o_flash,
    output logic [1:0] o_state,
    output logic [7:0] o_high_score
);

    localparam int DB_W = $clog2(DEBOUNCE_CYC + 1);
    localparam int FR_W = 8;

    localparam logic [DB_W-1:0] DB_LAST    = DB_W'(DEBOUNCE_CYC - 1);
    localparam logic [DB_W-1:0] DB_ONE     = DB_W'(1);
    localparam logic [FR_W-1:0] CRASH_LAST = FR_W'(CRASH_FRAMES - 1);
    localparam logic [FR_W-1:0] FLASH_LAST = FR_W'(FLASH_FRAMES - 1);
    localparam logic [FR_W-1:0] OVER_HOLD  = FR_W'(OVER_HOLD_FRAMES);
    localparam logic [FR_W-1:0] FR_ONE     = FR_W'(1);
    localparam logic [FR_W-1:0] FR_MAX     = '1;

    typedef enum logic [1:0] {
        ST_ATTRACT = 2'b00,
        ST_PLAY    = 2'b01,
        ST_CRASH   = 2'b10,
        ST_OVER    = 2'b11
    } state_t;

    logic            r_sync1;
    logic            r_sync2;
    logic            r_db;
    logic            r_db_d;
    logic [DB_W-1:0] r_db_cnt;
    logic            w_press;

    state_t          r_state;
    logic [FR_W-1:0] r_frame_cnt;
    logic [FR_W-1:0] r_flash_cnt;
    logic            r_flash;
    logic [FR_W-1:0] w_frame_inc;

    // The debounced level only follows the synced level after a full run of mismatches.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync1  <= 1'b0;
            r_sync2  <= 1'b0;
            r_db     <= 1'b0;
            r_db_d   <= 1'b0;
            r_db_cnt <= '0;
        end else begin
            r_sync1 <= i_move_btn;
            r_sync2 <= r_sync1;
            r_db_d  <= r_db;
            if (r_sync2 != r_db) begin
                if (r_db_cnt == DB_LAST) begin
                    r_db     <= r_sync2;
                    r_db_cnt <= '0;
                end else begin
                    r_db_cnt <= r_db_cnt + DB_ONE;
                end
            end else begin
                r_db_cnt <= '0;
            end
        end
    end

    assign w_press     = r_db & ~r_db_d;
    assign w_frame_inc = (r_frame_cnt == FR_MAX) ? r_frame_cnt : r_frame_cnt + FR_ONE;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= ST_ATTRACT;
            r_frame_cnt  <= '0;
            r_flash_cnt  <= '0;
            r_flash      <= 1'b0;
            o_state      <= ST_ATTRACT;
            o_game_rst   <= 1'b1;
            o_scroll_en  <= 1'b0;
            o_move_pulse <= 1'b0;
            o_flash      <= 1'b0;
            o_high_score <= 8'd0;
        end else begin
            case (r_state)
                ST_ATTRACT: begin
                    if (w_press) begin
                        r_state     <= ST_PLAY;
                        r_frame_cnt <= '0;
                        r_flash_cnt <= '0;
                    end
                end
                ST_PLAY: begin
                    if (i_collision) begin
                        r_state     <= ST_CRASH;
                        r_frame_cnt <= '0;
                        r_flash_cnt <= '0;
                        r_flash     <= 1'b1;
                    end
                end
                ST_CRASH: begin
                    if (i_frame_tick) begin
                        if (r_frame_cnt == CRASH_LAST) begin
                            r_state      <= ST_OVER;
                            r_frame_cnt  <= '0;
                            r_flash_cnt  <= '0;
                            o_high_score <= (i_score > o_high_score) ? i_score : o_high_score;
                        end else begin
                            r_frame_cnt <= w_frame_inc;
                            if (r_flash_cnt == FLASH_LAST) begin
                                r_flash_cnt <= '0;
                                r_flash     <= ~r_flash;
                            end else begin
                                r_flash_cnt <= r_flash_cnt + FR_ONE;
                            end
                        end
                    end
                end
                ST_OVER: begin
                    if (w_press && (r_frame_cnt >= OVER_HOLD)) begin
                        r_state     <= ST_PLAY;
                        r_frame_cnt <= '0;
                        r_flash_cnt <= '0;
                    end else if (i_frame_tick) begin
                        r_frame_cnt <= w_frame_inc;
                    end
                end
                default: r_state <= ST_ATTRACT;
            endcase

            // A collision in the same cycle as a press swallows the press.
            o_move_pulse <= (r_state == ST_PLAY) && w_press && !i_collision;
            o_state      <= r_state;
            o_game_rst   <= (r_state == ST_ATTRACT) || (r_state == ST_OVER);
            o_scroll_en  <= (r_state == ST_PLAY);
            o_flash      <= (r_state == ST_CRASH) && r_flash;
        end
    end

endmodule

// File: tb/tb_game_ctrl.sv
// Bench for game_ctrl: scripted vectors, hand-timed corner sequences and a
// randomized run against an event-level game model.
module tb_game_ctrl;

    localparam int DB = 4;
    localparam int CF = 6;
    localparam int FF = 2;
    localparam int OH = 3;

    localparam int OP_PRESS = 0;
    localparam int OP_TICK  = 1;
    localparam int OP_COLL  = 2;
    localparam int OP_CP    = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       btn = 1'b0;
    logic       tick = 1'b0;
    logic       coll = 1'b0;
    logic [7:0] score = 8'd0;
    logic       o_game_rst;
    logic       o_scroll_en;
    logic       o_move_pulse;
    logic       o_flash;
    logic [1:0] o_state;
    logic [7:0] o_high_score;

    game_ctrl #(
        .DEBOUNCE_CYC    (DB),
        .CRASH_FRAMES    (CF),
        .FLASH_FRAMES    (FF),
        .OVER_HOLD_FRAMES(OH)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_move_btn  (btn),
        .i_frame_tick(tick),
        .i_collision (coll),
        .i_score     (score),
        .o_game_rst  (o_game_rst),
        .o_scroll_en (o_scroll_en),
        .o_move_pulse(o_move_pulse),
        .o_flash     (o_flash),
        .o_state     (o_state),
        .o_high_score(o_high_score)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int pulse_cnt = 0;

    always @(negedge clk) if (o_move_pulse === 1'b1) pulse_cnt++;

    typedef struct {
        int op;
        int sc;
        int exp_state;
        int exp_rst;
        int exp_scroll;
        int exp_hs;
        int exp_pulses;
    } vec_t;

    vec_t vecs[$];

    // game model, tracked per event rather than per cycle
    int m_state;
    int m_cnt;
    int m_hs;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        btn = 1'b0; tick = 1'b0; coll = 1'b0; score = 8'd0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("reset state", 32'(o_state), 0);
        chk("reset game_rst", 32'(o_game_rst), 1);
        chk("reset scroll_en", 32'(o_scroll_en), 0);
        chk("reset move_pulse", 32'(o_move_pulse), 0);
        chk("reset flash", 32'(o_flash), 0);
        chk("reset high_score", 32'(o_high_score), 0);
        repeat (3) step();
        rst_n = 1'b1;
        repeat (2) step();
        m_state = 0; m_cnt = 0; m_hs = 0;
    endtask

    task automatic do_op(input int op);
        case (op)
            OP_PRESS: begin
                btn = 1'b1; repeat (12) step();
                btn = 1'b0; repeat (12) step();
            end
            OP_TICK: begin
                tick = 1'b1; step();
                tick = 1'b0; repeat (3) step();
            end
            OP_COLL: begin
                coll = 1'b1; step();
                coll = 1'b0; repeat (3) step();
            end
            default: begin
                // collision lands exactly in the cycle the debounced press appears
                btn = 1'b1; repeat (DB + 2) step();
                coll = 1'b1; step();
                coll = 1'b0; repeat (5) step();
                btn = 1'b0; repeat (12) step();
            end
        endcase
    endtask

    task automatic model_press(output int pulses);
        pulses = 0;
        if (m_state == 0) begin
            m_state = 1; m_cnt = 0;
        end else if (m_state == 1) begin
            pulses = 1;
        end else if (m_state == 3 && m_cnt >= OH) begin
            m_state = 1; m_cnt = 0;
        end
    endtask

    task automatic model_op(input int op, input int sc, output int pulses);
        pulses = 0;
        case (op)
            OP_PRESS: model_press(pulses);
            OP_TICK: begin
                if (m_state == 2) begin
                    m_cnt++;
                    if (m_cnt == CF) begin
                        m_state = 3; m_cnt = 0;
                        if (sc > m_hs) m_hs = sc;
                    end
                end else if (m_state == 3) begin
                    if (m_cnt < 255) m_cnt++;
                end
            end
            OP_COLL: begin
                if (m_state == 1) begin m_state = 2; m_cnt = 0; end
            end
            default: begin
                if (m_state == 1) begin m_state = 2; m_cnt = 0; end
                else model_press(pulses);
            end
        endcase
    endtask

    function automatic void add(input int op, input int sc, input int st, input int hs, input int p);
        vec_t v;
        v.op = op; v.sc = sc; v.exp_state = st;
        v.exp_rst = (st == 0 || st == 3) ? 1 : 0;
        v.exp_scroll = (st == 1) ? 1 : 0;
        v.exp_hs = hs; v.exp_pulses = p;
        vecs.push_back(v);
    endfunction

    initial begin
        int base;
        int exp_p;
        logic [5:0] flash_pat;

        do_reset();

        // first press starts the game and is not forwarded
        base = pulse_cnt;
        do_op(OP_PRESS);
        chk("start state", 32'(o_state), 1);
        chk("start game_rst", 32'(o_game_rst), 0);
        chk("start scroll_en", 32'(o_scroll_en), 1);
        chk("start no pulse", 32'(pulse_cnt - base), 0);

        base = pulse_cnt;
        btn = 1'b1; repeat (3) step();
        btn = 1'b0; repeat (20) step();
        chk("glitch no pulse", 32'(pulse_cnt - base), 0);

        base = pulse_cnt;
        btn = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("pulse timing edge %0d", k), 32'(o_move_pulse), (k == DB + 3) ? 1 : 0);
        end
        btn = 1'b0;
        repeat (15) step();
        chk("one pulse per press", 32'(pulse_cnt - base), 1);

        base = pulse_cnt;
        do_op(OP_PRESS);
        chk("second press pulse", 32'(pulse_cnt - base), 1);

        // collision together with a press, then the full flash sequence
        base = pulse_cnt;
        score = 8'd37;
        do_op(OP_CP);
        chk("cp state", 32'(o_state), 2);
        chk("cp no pulse", 32'(pulse_cnt - base), 0);
        chk("cp scroll_en", 32'(o_scroll_en), 0);
        chk("cp game_rst", 32'(o_game_rst), 0);
        flash_pat = 6'b110011;
        for (int k = 0; k < CF; k++) begin
            chk($sformatf("flash before tick %0d", k + 1), 32'(o_flash), 32'(flash_pat[5-k]));
            chk($sformatf("crash state tick %0d", k + 1), 32'(o_state), 2);
            do_op(OP_TICK);
        end
        chk("over state", 32'(o_state), 3);
        chk("over game_rst", 32'(o_game_rst), 1);
        chk("over flash", 32'(o_flash), 0);
        chk("high score 37", 32'(o_high_score), 37);

        repeat (2) do_op(OP_TICK);
        do_op(OP_PRESS);
        chk("hold press ignored", 32'(o_state), 3);
        do_op(OP_TICK);
        do_op(OP_PRESS);
        chk("hold press accepted", 32'(o_state), 1);

        // asynchronous reset in the middle of a game
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("midgame reset state", 32'(o_state), 0);
        chk("midgame reset hs", 32'(o_high_score), 0);
        chk("midgame reset game_rst", 32'(o_game_rst), 1);
        chk("midgame reset scroll", 32'(o_scroll_en), 0);
        repeat (2) step();
        rst_n = 1'b1;
        repeat (2) step();

        // scripted vectors
        add(OP_PRESS, 0, 1, 0, 0);
        add(OP_PRESS, 0, 1, 0, 1);
        add(OP_COLL, 37, 2, 0, 0);
        for (int i = 0; i < CF - 1; i++) add(OP_TICK, 37, 2, 0, 0);
        add(OP_TICK, 37, 3, 37, 0);
        add(OP_TICK, 37, 3, 37, 0);
        add(OP_TICK, 37, 3, 37, 0);
        add(OP_PRESS, 37, 3, 37, 0);
        add(OP_TICK, 37, 3, 37, 0);
        add(OP_PRESS, 12, 1, 37, 0);
        add(OP_CP, 12, 2, 37, 0);
        for (int i = 0; i < CF - 1; i++) add(OP_TICK, 12, 2, 37, 0);
        add(OP_TICK, 12, 3, 37, 0);

        do_reset();
        for (int i = 0; i < vecs.size(); i++) begin
            score = 8'(vecs[i].sc);
            base = pulse_cnt;
            do_op(vecs[i].op);
            chk($sformatf("vec %0d state", i), 32'(o_state), 32'(vecs[i].exp_state));
            chk($sformatf("vec %0d game_rst", i), 32'(o_game_rst), 32'(vecs[i].exp_rst));
            chk($sformatf("vec %0d scroll_en", i), 32'(o_scroll_en), 32'(vecs[i].exp_scroll));
            chk($sformatf("vec %0d high_score", i), 32'(o_high_score), 32'(vecs[i].exp_hs));
            chk($sformatf("vec %0d pulses", i), 32'(pulse_cnt - base), 32'(vecs[i].exp_pulses));
        end

        // randomized play against the model
        do_reset();
        for (int i = 0; i < 160; i++) begin
            int r;
            int op;
            r = $urandom_range(0, 9);
            op = (r < 3) ? OP_PRESS : (r < 8) ? OP_TICK : (r == 8) ? OP_COLL : OP_CP;
            score = 8'($urandom_range(0, 255));
            base = pulse_cnt;
            do_op(op);
            model_op(op, int'(score), exp_p);
            chk($sformatf("rnd %0d op %0d state", i, op), 32'(o_state), 32'(m_state));
            chk($sformatf("rnd %0d game_rst", i), 32'(o_game_rst), (m_state == 0 || m_state == 3) ? 1 : 0);
            chk($sformatf("rnd %0d scroll_en", i), 32'(o_scroll_en), (m_state == 1) ? 1 : 0);
            chk($sformatf("rnd %0d flash", i), 32'(o_flash), (m_state == 2 && ((m_cnt / FF) % 2 == 0)) ? 1 : 0);
            chk($sformatf("rnd %0d high_score", i), 32'(o_high_score), 32'(m_hs));
            chk($sformatf("rnd %0d pulses", i), 32'(pulse_cnt - base), 32'(exp_p));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
